// File: rtl/run_ctrl.sv
// Run sequencer: holds the core stalled while idle, loads its PC, releases it
// to run, and stops it on halt or watchdog expiry with a cycle count.
module run_ctrl #(
  parameter int PC_W    = 10,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartPc,
  input  logic             Done,
  output logic             CoreHold,
  output logic             PcLoad,
  output logic [PC_W-1:0]  PcInit,
  output logic             Ack,
  output logic             Timeout,
  output logic [CYC_W-1:0] CycleCount
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  localparam bit   WD_EN = (TIMEOUT != 0);
  localparam int   CMP_W = (CYC_W > 32) ? CYC_W : 32;
  localparam logic [CMP_W-1:0] WD_LAST = CMP_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_init_q, pc_init_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic              timeout_q, timeout_d;
  logic              hold_q, hold_d;
  logic              pc_load_q, pc_load_d;
  logic              ack_q, ack_d;
  logic              wd_hit;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (&v) ? v : v + CYC_W'(1);
  endfunction

  // Count is compared in a widened domain so limits beyond the counter range never fire.
  assign wd_hit = WD_EN && (CMP_W'(cyc_q) == WD_LAST);

  always_comb begin
    state_d   = state_q;
    pc_init_d = pc_init_q;
    cyc_d     = cyc_q;
    timeout_d = timeout_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          state_d   = S_LOAD;
          pc_init_d = StartPc;
          cyc_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: state_d = S_ARM;
      S_ARM: begin
        if (!Start) state_d = S_RUN;
      end
      S_RUN: begin
        cyc_d = sat_inc(cyc_q);
        if (Done) begin
          state_d   = S_DONE;
          timeout_d = 1'b0;
        end else if (wd_hit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are decoded from the next state so they are registered yet aligned with it.
    hold_d    = (state_d != S_RUN);
    pc_load_d = (state_d == S_LOAD);
    ack_d     = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= S_IDLE;
      pc_init_q <= '0;
      cyc_q     <= '0;
      timeout_q <= 1'b0;
      hold_q    <= 1'b1;
      pc_load_q <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_init_q <= pc_init_d;
      cyc_q     <= cyc_d;
      timeout_q <= timeout_d;
      hold_q    <= hold_d;
      pc_load_q <= pc_load_d;
      ack_q     <= ack_d;
    end
  end

  assign CoreHold   = hold_q;
  assign PcLoad     = pc_load_q;
  assign PcInit     = pc_init_q;
  assign Ack        = ack_q;
  assign Timeout    = timeout_q;
  assign CycleCount = cyc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Bench for run_ctrl: cycle-by-cycle vector table with a scoreboard queue,
// plus a saturation sequence on a small-counter, watchdog-disabled instance.
module tb_run_ctrl;

  logic        Clk;
  logic        Reset;
  logic        Start;
  logic [9:0]  StartPc;
  logic        Done;
  logic        CoreHold, PcLoad, Ack, Timeout;
  logic [9:0]  PcInit;
  logic [15:0] CycleCount;

  logic        rst2_n, start2, done2;
  logic [9:0]  pc2;
  logic        hold2, pcl2, ack2, to2;
  logic [9:0]  init2;
  logic [3:0]  cyc2;

  run_ctrl #(.PC_W(10), .CYC_W(16), .TIMEOUT(20)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartPc(StartPc), .Done(Done),
    .CoreHold(CoreHold), .PcLoad(PcLoad), .PcInit(PcInit), .Ack(Ack),
    .Timeout(Timeout), .CycleCount(CycleCount)
  );

  run_ctrl #(.PC_W(10), .CYC_W(4), .TIMEOUT(0)) dut_sat (
    .Clk(Clk), .Reset(rst2_n), .Start(start2), .StartPc(pc2), .Done(done2),
    .CoreHold(hold2), .PcLoad(pcl2), .PcInit(init2), .Ack(ack2),
    .Timeout(to2), .CycleCount(cyc2)
  );

  typedef struct packed {
    logic        hold;
    logic        pcl;
    logic [9:0]  init;
    logic        ack;
    logic        to;
    logic [15:0] cyc;
  } out_t;

  typedef struct packed {
    logic       rst_n;
    logic       start;
    logic [9:0] pc;
    logic       done;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic out_t o(logic h, logic p, logic [9:0] i, logic a, logic t, int c);
    out_t r;
    r.hold = h; r.pcl = p; r.init = i; r.ack = a; r.to = t; r.cyc = 16'(c);
    return r;
  endfunction

  task automatic add(logic r, logic s, logic [9:0] pc, logic d, out_t e);
    vec_t v;
    v.rst_n = r; v.start = s; v.pc = pc; v.done = d; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    out_t got, e;
    int   n;

    Reset = 1'b0; Start = 1'b0; StartPc = '0; Done = 1'b0;
    rst2_n = 1'b0; start2 = 1'b0; done2 = 1'b0; pc2 = '0;

    // Reset state, Done ignored in IDLE
    add(0, 0, 10'h000, 0, o(1, 0, 10'h000, 0, 0, 0));
    add(1, 0, 10'h000, 1, o(1, 0, 10'h000, 0, 0, 0));
    add(1, 0, 10'h000, 0, o(1, 0, 10'h000, 0, 0, 0));
    // Run 1: one-cycle Start, StartPc changes after capture, Done on 7th RUN cycle
    add(1, 1, 10'h020, 0, o(1, 1, 10'h020, 0, 0, 0));
    add(1, 0, 10'h3ff, 0, o(1, 0, 10'h020, 0, 0, 0));
    add(1, 0, 10'h3ff, 0, o(0, 0, 10'h020, 0, 0, 0));
    for (int k = 1; k <= 6; k++) add(1, 0, 10'h3ff, 0, o(0, 0, 10'h020, 0, 0, k));
    add(1, 0, 10'h3ff, 1, o(1, 0, 10'h020, 1, 0, 7));
    add(1, 0, 10'h3ff, 1, o(1, 0, 10'h020, 1, 0, 7));
    // Run 2 from DONE: Start held 4 cycles, Done after 3 RUN cycles
    add(1, 1, 10'h100, 0, o(1, 1, 10'h100, 0, 0, 0));
    for (int k = 0; k < 3; k++) add(1, 1, 10'h100, 0, o(1, 0, 10'h100, 0, 0, 0));
    add(1, 0, 10'h100, 0, o(0, 0, 10'h100, 0, 0, 0));
    add(1, 0, 10'h100, 0, o(0, 0, 10'h100, 0, 0, 1));
    add(1, 0, 10'h100, 0, o(0, 0, 10'h100, 0, 0, 2));
    add(1, 0, 10'h100, 1, o(1, 0, 10'h100, 1, 0, 3));
    // Run 3: watchdog expiry after 20 RUN cycles
    add(1, 1, 10'h055, 0, o(1, 1, 10'h055, 0, 0, 0));
    add(1, 0, 10'h055, 0, o(1, 0, 10'h055, 0, 0, 0));
    add(1, 0, 10'h055, 0, o(0, 0, 10'h055, 0, 0, 0));
    for (int k = 1; k <= 19; k++) add(1, 0, 10'h055, 0, o(0, 0, 10'h055, 0, 0, k));
    add(1, 0, 10'h055, 0, o(1, 0, 10'h055, 1, 1, 20));
    // Run 4: Done coincides with the watchdog limit, Timeout cleared at LOAD
    add(1, 1, 10'h0aa, 0, o(1, 1, 10'h0aa, 0, 0, 0));
    add(1, 0, 10'h0aa, 0, o(1, 0, 10'h0aa, 0, 0, 0));
    add(1, 0, 10'h0aa, 0, o(0, 0, 10'h0aa, 0, 0, 0));
    for (int k = 1; k <= 19; k++) add(1, 0, 10'h0aa, 0, o(0, 0, 10'h0aa, 0, 0, k));
    add(1, 0, 10'h0aa, 1, o(1, 0, 10'h0aa, 1, 0, 20));
    // Run 5: reset at CycleCount=5, then a normal run
    add(1, 1, 10'h033, 0, o(1, 1, 10'h033, 0, 0, 0));
    add(1, 0, 10'h033, 0, o(1, 0, 10'h033, 0, 0, 0));
    add(1, 0, 10'h033, 0, o(0, 0, 10'h033, 0, 0, 0));
    for (int k = 1; k <= 5; k++) add(1, 0, 10'h033, 0, o(0, 0, 10'h033, 0, 0, k));
    add(0, 0, 10'h033, 0, o(1, 0, 10'h000, 0, 0, 0));
    add(1, 0, 10'h033, 0, o(1, 0, 10'h000, 0, 0, 0));
    add(1, 1, 10'h044, 0, o(1, 1, 10'h044, 0, 0, 0));
    add(1, 0, 10'h044, 0, o(1, 0, 10'h044, 0, 0, 0));
    add(1, 0, 10'h044, 0, o(0, 0, 10'h044, 0, 0, 0));
    add(1, 0, 10'h044, 0, o(0, 0, 10'h044, 0, 0, 1));
    add(1, 0, 10'h044, 1, o(1, 0, 10'h044, 1, 0, 2));

    foreach (vecs[i]) begin
      @(negedge Clk);
      Reset   = vecs[i].rst_n;
      Start   = vecs[i].start;
      StartPc = vecs[i].pc;
      Done    = vecs[i].done;
      exp_q.push_back(vecs[i].exp);
      @(posedge Clk);
      #1;
      got = {CoreHold, PcLoad, PcInit, Ack, Timeout, CycleCount};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL vec%0d actual hold=%b pcl=%b init=%h ack=%b to=%b cyc=%0d required hold=%b pcl=%b init=%h ack=%b to=%b cyc=%0d",
                 i, got.hold, got.pcl, got.init, got.ack, got.to, got.cyc,
                 e.hold, e.pcl, e.init, e.ack, e.to, e.cyc);
      end
    end

    // Saturating counter with the watchdog disabled
    @(negedge Clk);
    Start = 1'b0; Done = 1'b0;
    rst2_n = 1'b1; start2 = 1'b1; pc2 = 10'h001;
    @(negedge Clk);
    start2 = 1'b0;
    chk("sat_pcload", 32'(pcl2), 32'd1);
    n = 0;
    while (hold2 && n < 10) begin
      @(posedge Clk);
      #1;
      n++;
    end
    chk("sat_run_entry", 32'(hold2), 32'd0);
    repeat (20) @(posedge Clk);
    #1;
    chk("sat_count", 32'(cyc2), 32'd15);
    chk("sat_no_watchdog", 32'(hold2), 32'd0);
    chk("sat_pcinit", 32'(init2), 32'h001);
    @(negedge Clk);
    done2 = 1'b1;
    @(posedge Clk);
    #1;
    chk("sat_ack", 32'(ack2), 32'd1);
    chk("sat_final_count", 32'(cyc2), 32'd15);
    chk("sat_timeout", 32'(to2), 32'd0);
    @(negedge Clk);
    done2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
# run_ctrl

Run sequencer for the basic processor. It sits between the bench/host Start/Ack handshake and the core. It holds the core stalled while idle, loads the program counter with a start address, and releases the core to run. It stops the core on its Done (halt) indication or on a watchdog timeout, reports the run's cycle count, and raises Ack until the next Start.

## Interface
Parameters:
- PC_W, 10, program-counter width
- CYC_W, 16, cycle-counter width
- TIMEOUT, 1000, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-low (0 = reset asserted)
- Start  in  1  run request from host/bench, level-sampled
- StartPc  in  PC_W  start address, captured when Start is accepted
- Done  in  1  core halt indication, valid only in RUN
- CoreHold  out  1  1 = core stalled (PC and register-file/memory writes frozen)
- PcLoad  out  1  one-cycle strobe; core loads PcInit into its PC
- PcInit  out  PC_W  registered start address
- Ack  out  1  run finished; held until next accepted Start
- Timeout  out  1  last run ended by watchdog, valid while Ack=1
- CycleCount  out  CYC_W  RUN cycles of the current/last run

## Operation
- All outputs are registered.
- Reset values: state IDLE, CoreHold=1, PcLoad=0, PcInit=0, Ack=0, Timeout=0, CycleCount=0.
- Reset asserted at any time, including mid-RUN, forces the reset values immediately; no run resumes after release.

States and transitions:
- IDLE: CoreHold=1. Start=1 -> LOAD; capture StartPc into PcInit; clear CycleCount and Timeout.
- LOAD: PcLoad=1 for exactly this cycle; CoreHold=1; Ack=0. Unconditional -> ARM.
- ARM: CoreHold=1. Waits for Start=0 so that a held Start cannot retrigger. Start=0 -> RUN.
- RUN: CoreHold=0. CycleCount increments every RUN cycle.
  - Done=1 -> DONE, Timeout=0.
  - Else, TIMEOUT≠0 and CycleCount==TIMEOUT-1 -> DONE, Timeout=1.
  - Start is ignored in RUN.
- DONE: CoreHold=1, Ack=1. CycleCount and Timeout hold. Start=1 -> LOAD (new run) with the same capture as from IDLE.

Boundary rules:
- CycleCount saturates at all-ones, never wraps. This matters only when TIMEOUT=0 or TIMEOUT > 2^CYC_W-1.
- Done and the watchdog limit in the same cycle: Done wins, Timeout=0.
- Done outside RUN is ignored.
- StartPc changes after capture have no effect on the current run.

## Timing
- Start sampled high at edge N (IDLE/DONE) -> PcLoad=1 and PcInit valid during cycle N+1 -> ARM in N+2.
- If Start is already low at the N+2 edge, CoreHold falls at N+3. Minimum Start-to-run latency is 3 cycles.
- Ack falls in the cycle after Start is accepted from DONE, i.e. in LOAD.
- Done sampled at the edge ending the k-th RUN cycle -> Ack=1 and CoreHold=1 in the next cycle; CycleCount=k.
- The core executes no instruction in the cycle Ack rises.
- Watchdog: Ack=1 with Timeout=1 and CycleCount=TIMEOUT in the cycle after the TIMEOUT-th RUN cycle.

## Test plan
- Reset mid-RUN (CycleCount=5) -> next cycle: CoreHold=1, Ack=0, CycleCount=0; state IDLE. Start after release runs normally.
- StartPc=10'h020, one-cycle Start pulse, Done raised on the 7th RUN cycle:
  - PcLoad is a single-cycle pulse with PcInit=10'h020.
  - CoreHold=0 for exactly 7 cycles.
  - Then Ack=1, Timeout=0, CycleCount=7.
- Start held high for 4 cycles -> RUN entered only after Start drops. Exactly one PcLoad pulse.
- TIMEOUT=20, Done never asserted -> Ack=1, Timeout=1, CycleCount=20, CoreHold=1.
- TIMEOUT=20, Done on the 20th RUN cycle -> Ack=1, Timeout=0, CycleCount=20.
- From DONE, Start with StartPc=10'h100:
  - Ack falls the next cycle; PcInit=10'h100; CycleCount restarts from 0.
  - Second run with Done after 3 cycles -> CycleCount=3.
